frame_sched: RTL and testbench

//  Frame-level scheduler for the lava-lamp render path: sequences the metaball engine over

---
 rtl/lava_pkg.sv | 21 ++
 rtl/raster_cnt.sv | 40 ++++
 rtl/frame_sched.sv | 120 ++++++++++++
 tb/tb_frame_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lava_pkg.sv
// Shared types and default geometry for the lava-lamp render path.
// Frame size defaults and the scheduler state encoding live here.
package lava_pkg;

    localparam int H_RES_DFLT  = 64;
    localparam int V_RES_DFLT  = 32;
    localparam int PIX_W_DFLT  = 8;
    localparam int DROP_W_DFLT = 8;
    localparam int ADDR_W      = $clog2(H_RES_DFLT * V_RES_DFLT);

    typedef logic [PIX_W_DFLT-1:0] pix_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/raster_cnt.sv
// Raster-order x/y counter with x advancing fastest.
// It wraps to (0,0) after the last pixel and flags that last pixel.
module raster_cnt #(
    parameter int  H_RES = 64,
    parameter int  V_RES = 32,
    localparam int XW    = $clog2(H_RES),
    localparam int YW    = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: drives the metaball engine over every back-bank pixel and
// swaps front/back banks only on a vsync that finds a finished frame.
module frame_sched
    import lava_pkg::*;
#(
    parameter int  H_RES  = H_RES_DFLT,
    parameter int  V_RES  = V_RES_DFLT,
    parameter int  PIX_W  = PIX_W_DFLT,
    parameter int  DROP_W = DROP_W_DFLT,
    localparam int XW     = $clog2(H_RES),
    localparam int YW     = $clog2(V_RES),
    localparam int AW     = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              vsync,
    output logic              step,
    input  logic              step_done,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [XW-1:0]     px_x,
    output logic [YW-1:0]     px_y,
    input  logic              res_valid,
    input  logic [PIX_W-1:0]  res_data,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [AW-1:0]     wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              front_bank,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt,
    output sched_state_e      state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);

    logic          issue_last;
    logic          px_fire;
    logic          final_wr;
    logic [AW-1:0] wr_cnt;

    // Handshake: a coordinate transfers on a cycle where px_valid && px_ready;
    // px_valid never drops and px_x/px_y never change while px_ready is low.
    assign px_valid = (state == S_ISSUE);
    assign px_fire  = px_valid && px_ready;
    assign busy     = (state == S_STEP) || (state == S_ISSUE) || (state == S_DRAIN);

    // Results stream straight into the back bank, possibly while issue is still running.
    assign wr_en    = res_valid && ((state == S_ISSUE) || (state == S_DRAIN));
    assign wr_data  = wr_en ? res_data : '0;
    assign wr_addr  = wr_cnt;
    assign wr_bank  = ~front_bank;
    assign final_wr = wr_en && (wr_cnt == LAST_ADDR);

    raster_cnt #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_issue (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_IDLE),
        .advance (px_fire),
        .x       (px_x),
        .y       (px_y),
        .last    (issue_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= 1'b0;
            front_bank <= 1'b0;
            drop_cnt   <= '0;
            wr_cnt     <= '0;
        end else begin
            step <= 1'b0;
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            // A vsync that arrives while the frame is still being built is a missed frame.
            if (vsync && busy && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state  <= S_STEP;
                        step   <= 1'b1;
                        wr_cnt <= '0;
                    end
                end
                S_STEP: begin
                    if (step_done) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (px_fire && issue_last) begin
                        state <= final_wr ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (final_wr) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Going through IDLE puts the next step one cycle after the swap.
                    if (vsync) begin
                        front_bank <= ~front_bank;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Scoreboard bench for frame_sched on a 4x2 frame with a 3-cycle metaball model.
module tb_frame_sched;
    import lava_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        vsync = 1'b0;
    logic        step;
    logic        step_done = 1'b1;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic [1:0]  px_x;
    logic        px_y;
    logic        res_valid = 1'b0;
    logic [7:0]  res_data = 8'h00;
    logic        wr_en;
    logic        wr_bank;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        front_bank;
    logic        busy;
    logic [7:0]  drop_cnt;
    sched_state_e state;

    int total = 0;
    int bad = 0;
    int issue_idx = 0;
    int wr_count = 0;
    int step_cnt = 0;
    logic exp_front = 1'b0;
    logic rand_ready = 1'b0;
    logic [11:0] exp_q[$];

    logic       hs_flag = 1'b0;
    logic [7:0] hs_val = 8'h00;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00;

    frame_sched #(.H_RES(4), .V_RES(2), .PIX_W(8), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .vsync      (vsync),
        .step       (step),
        .step_done  (step_done),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .front_bank (front_bank),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_fn(int x, int y);
        return 8'((x * 37 + y * 101 + 5) & 255);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Metaball model: result appears three edges after the accepting handshake.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                v1 = 1'b0; v2 = 1'b0; res_valid = 1'b0;
            end else begin
                res_valid = v2; res_data = d2;
                v2 = v1; d2 = d1;
                v1 = hs_flag; d1 = hs_val;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            px_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pushes the expected write at each handshake, pops on each write.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            issue_idx = 0;
            hs_flag = 1'b0;
        end else begin
            if (step) step_cnt++;
            hs_flag = px_valid && px_ready;
            hs_val = pix_fn(int'(px_x), int'(px_y));
            if (px_valid && px_ready) begin
                check("px_x", 32'(px_x), 32'(issue_idx % 4));
                check("px_y", 32'(px_y), 32'((issue_idx / 4) % 2));
                exp_q.push_back({~exp_front, 3'(issue_idx % 8),
                                 pix_fn(issue_idx % 4, (issue_idx / 4) % 2)});
                issue_idx++;
            end
            if (wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'({wr_bank, wr_addr, wr_data}), 32'hfff);
                end else begin
                    check("wr_bank_addr_data", 32'({wr_bank, wr_addr, wr_data}),
                          32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_state(sched_state_e s, int budget, string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) return;
        end
        check({"timeout_", name}, 32'(state), 32'(s));
    endtask

    task automatic pulse_vsync();
        @(posedge clk);
        #1 vsync = 1'b1;
        @(posedge clk);
        #1 vsync = 1'b0;
    endtask

    task automatic frame_end_checks(int wr_before, string name);
        check({name, "_writes"}, 32'(wr_count - wr_before), 32'd8);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int wr_before;
        int steps_before;
        bit hit;

        // 1: reset state
        repeat (2) @(negedge clk);
        check("rst_front_bank", 32'(front_bank), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_px_valid", 32'(px_valid), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        // 2: one full frame, then swap and the next step pulse
        wr_before = wr_count;
        en = 1'b1;
        wait_state(S_DONE, 100, "frame1_done");
        check("f1_step_count", 32'(step_cnt), 32'd1);
        frame_end_checks(wr_before, "f1");
        pulse_vsync();
        @(negedge clk);
        check("f1_swap_front", 32'(front_bank), 32'd1);
        exp_front = 1'b1;
        rand_ready = 1'b1;
        @(negedge clk);
        check("f2_step_pulse", 32'(step), 32'd1);

        // 3: random backpressure frame
        wr_before = wr_count;
        wait_state(S_DONE, 300, "frame2_done");
        frame_end_checks(wr_before, "f2");
        check("f2_issue_total", 32'(issue_idx), 32'd16);
        rand_ready = 1'b0;

        // 4: vsync while issuing is a drop, vsync in DONE swaps
        pulse_vsync();
        @(negedge clk);
        check("f2_swap_front", 32'(front_bank), 32'd0);
        exp_front = 1'b0;
        wait_state(S_ISSUE, 50, "f3_issue");
        vsync = 1'b1;
        @(posedge clk);
        #1 vsync = 1'b0;
        @(negedge clk);
        check("f3_drop_front", 32'(front_bank), 32'd0);
        check("f3_drop_cnt", 32'(drop_cnt), 32'd1);
        wait_state(S_DONE, 100, "f3_done");
        pulse_vsync();
        @(negedge clk);
        check("f3_swap_front", 32'(front_bank), 32'd1);
        exp_front = 1'b1;

        // 5: vsync coincident with the final write still counts as a drop
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 3'd7) hit = 1'b1;
        end
        check("f4_saw_last_write", 32'(hit), 32'd1);
        vsync = 1'b1;
        @(posedge clk);
        #1 vsync = 1'b0;
        @(negedge clk);
        check("f4_drop_cnt", 32'(drop_cnt), 32'd2);
        check("f4_no_swap", 32'(front_bank), 32'd1);
        check("f4_state_done", 32'(state), 32'(S_DONE));
        step_done = 1'b0;
        pulse_vsync();
        @(negedge clk);
        check("f4_swap_front", 32'(front_bank), 32'd0);
        exp_front = 1'b0;
        wait_state(S_STEP, 20, "f5_step");
        for (int i = 0; i < 300; i++) pulse_vsync();
        @(negedge clk);
        check("drop_saturate", 32'(drop_cnt), 32'd255);
        check("drop_no_swap", 32'(front_bank), 32'd0);
        step_done = 1'b1;
        wr_before = wr_count;
        wait_state(S_DONE, 100, "f5_done");
        frame_end_checks(wr_before, "f5");
        pulse_vsync();
        @(negedge clk);
        check("f5_swap_front", 32'(front_bank), 32'd1);
        exp_front = 1'b1;

        // 6: en dropped mid-frame finishes the frame, swaps, then idles
        wait_state(S_ISSUE, 50, "f6_issue");
        en = 1'b0;
        wr_before = wr_count;
        wait_state(S_DONE, 100, "f6_done");
        frame_end_checks(wr_before, "f6");
        steps_before = step_cnt;
        pulse_vsync();
        @(negedge clk);
        check("f6_swap_front", 32'(front_bank), 32'd0);
        exp_front = 1'b0;
        repeat (5) @(negedge clk);
        check("f6_idle", 32'(state), 32'(S_IDLE));
        check("f6_no_step", 32'(step_cnt), 32'(steps_before));

        // async reset in the middle of DRAIN
        en = 1'b1;
        wait_state(S_DRAIN, 50, "f7_drain");
        @(posedge clk);
        #3 rst = 1'b1;
        en = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'(S_IDLE));
        check("mid_rst_front", 32'(front_bank), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_px_valid", 32'(px_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'(state), 32'(S_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
